// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_arbiter_if
//  Purpose  : Requester-side command/response bundle for ram_port_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_ADDR  = 3
);
    logic                  req;
    logic                  we;
    logic [DATA_ADDR-1:0]  addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  done;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, done, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, done, rdata);
endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_arbiter
//  Purpose  : Round-robin two-requester sequencer for an async single-port RAM
//             with a shared tri-state data bus and a turnaround cycle per write.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_ADDR  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_port_arbiter_if.slave     port_a,
    ram_port_arbiter_if.slave     port_b,
    output logic                  busy,
    output logic [DATA_ADDR-1:0]  ram_addr,
    output logic                  ram_we,
    output logic                  ram_en,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_WR_HOLD = 2'd2,
        ST_RD      = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_sel_b;
    logic                  r_last_b;
    logic [DATA_ADDR-1:0]  r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_drive;
    logic                  r_we;
    logic                  r_en;
    logic                  r_busy;
    logic                  r_gnt_a;
    logic                  r_gnt_b;
    logic                  r_done_a;
    logic                  r_done_b;
    logic [DATA_WIDTH-1:0] r_rdata_a;
    logic [DATA_WIDTH-1:0] r_rdata_b;

    state_t                w_state_nxt;
    logic                  w_sel_b_nxt;
    logic                  w_last_b_nxt;
    logic [DATA_ADDR-1:0]  w_addr_nxt;
    logic [DATA_WIDTH-1:0] w_wdata_nxt;
    logic                  w_drive_nxt;
    logic                  w_we_nxt;
    logic                  w_en_nxt;
    logic                  w_gnt_a_nxt;
    logic                  w_gnt_b_nxt;
    logic                  w_done_a_nxt;
    logic                  w_done_b_nxt;
    logic [DATA_WIDTH-1:0] w_rdata_a_nxt;
    logic [DATA_WIDTH-1:0] w_rdata_b_nxt;
    logic                  w_pick_b;

    // On a tie the requester that was not served last wins.
    assign w_pick_b = port_b.req & (~port_a.req | ~r_last_b);

    always_comb begin
        w_state_nxt   = r_state;
        w_sel_b_nxt   = r_sel_b;
        w_last_b_nxt  = r_last_b;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_drive_nxt   = 1'b0;
        w_we_nxt      = 1'b0;
        w_en_nxt      = 1'b0;
        w_gnt_a_nxt   = 1'b0;
        w_gnt_b_nxt   = 1'b0;
        w_done_a_nxt  = 1'b0;
        w_done_b_nxt  = 1'b0;
        w_rdata_a_nxt = r_rdata_a;
        w_rdata_b_nxt = r_rdata_b;

        case (r_state)
            ST_IDLE: begin
                if (port_a.req | port_b.req) begin
                    w_sel_b_nxt  = w_pick_b;
                    w_last_b_nxt = w_pick_b;
                    w_addr_nxt   = w_pick_b ? port_b.addr  : port_a.addr;
                    w_wdata_nxt  = w_pick_b ? port_b.wdata : port_a.wdata;
                    w_gnt_a_nxt  = ~w_pick_b;
                    w_gnt_b_nxt  = w_pick_b;
                    if (w_pick_b ? port_b.we : port_a.we) begin
                        w_state_nxt = ST_WR;
                        w_we_nxt    = 1'b1;
                        w_drive_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_RD;
                        w_en_nxt    = 1'b1;
                    end
                end
            end
            ST_WR: begin
                // Keep address and data on the bus one more cycle for RAM hold time.
                w_state_nxt  = ST_WR_HOLD;
                w_drive_nxt  = 1'b1;
                w_done_a_nxt = ~r_sel_b;
                w_done_b_nxt = r_sel_b;
            end
            ST_WR_HOLD: begin
                w_state_nxt = ST_IDLE;
            end
            ST_RD: begin
                w_state_nxt  = ST_IDLE;
                w_done_a_nxt = ~r_sel_b;
                w_done_b_nxt = r_sel_b;
                if (r_sel_b) begin
                    w_rdata_b_nxt = ram_data;
                end else begin
                    w_rdata_a_nxt = ram_data;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sel_b   <= 1'b0;
            r_last_b  <= 1'b1;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_drive   <= 1'b0;
            r_we      <= 1'b0;
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
            r_gnt_a   <= 1'b0;
            r_gnt_b   <= 1'b0;
            r_done_a  <= 1'b0;
            r_done_b  <= 1'b0;
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel_b   <= w_sel_b_nxt;
            r_last_b  <= w_last_b_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_drive   <= w_drive_nxt;
            r_we      <= w_we_nxt;
            r_en      <= w_en_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_gnt_a   <= w_gnt_a_nxt;
            r_gnt_b   <= w_gnt_b_nxt;
            r_done_a  <= w_done_a_nxt;
            r_done_b  <= w_done_b_nxt;
            r_rdata_a <= w_rdata_a_nxt;
            r_rdata_b <= w_rdata_b_nxt;
        end
    end

    assign ram_data     = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};
    assign ram_addr     = r_addr;
    assign ram_we       = r_we;
    assign ram_en       = r_en;
    assign busy         = r_busy;
    assign port_a.gnt   = r_gnt_a;
    assign port_a.done  = r_done_a;
    assign port_a.rdata = r_rdata_a;
    assign port_b.gnt   = r_gnt_b;
    assign port_b.done  = r_done_b;
    assign port_b.rdata = r_rdata_b;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_port_arbiter
//  Purpose  : Scoreboard bench for ram_port_arbiter with an async RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int QN    = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.DATA_WIDTH(DW), .DATA_ADDR(AW)) a_if ();
    ram_port_arbiter_if #(.DATA_WIDTH(DW), .DATA_ADDR(AW)) b_if ();

    logic          busy;
    logic          ram_we;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;

    ram_port_arbiter #(.DATA_WIDTH(DW), .DATA_ADDR(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .port_a   (a_if),
        .port_b   (b_if),
        .busy     (busy),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_en   (ram_en),
        .ram_data (ram_data)
    );

    // Asynchronous RAM macro: write strobe sampled mid-cycle, read drives the bus.
    logic [DW-1:0] tb_mem [DEPTH] = '{default: '0};
    always @(negedge clk) begin
        if (ram_we && !ram_en) tb_mem[ram_addr] <= ram_data;
    end
    assign ram_data = (ram_en && !ram_we) ? tb_mem[ram_addr] : {DW{1'bz}};

    // ---------------- reference model: one access at a time, RR on ties ----
    typedef struct {
        int          cyc;
        bit          is_rd;
        logic [DW-1:0] data;
    } exp_t;

    logic [DW-1:0] ref_mem [DEPTH] = '{default: '0};
    int            gq [2][QN];
    exp_t          dq [2][QN];
    int            tl [2] = '{0, 0};
    int            cyc      = 0;
    int            busy_cnt = 0;
    bit            last_b   = 1'b1;
    int            wr_cyc   = -1;
    int            rd_cyc   = -1;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    bit            m_pick_b;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                busy_cnt = 0;
                last_b   = 1'b1;
                wr_cyc   = -1;
                rd_cyc   = -1;
            end else begin
                cyc = cyc + 1;
                if (busy_cnt > 0) begin
                    busy_cnt = busy_cnt - 1;
                end else if (a_if.req || b_if.req) begin
                    if (a_if.req && b_if.req) m_pick_b = !last_b;
                    else                      m_pick_b = b_if.req;
                    last_b = m_pick_b;
                    m_we   = m_pick_b ? b_if.we    : a_if.we;
                    m_addr = m_pick_b ? b_if.addr  : a_if.addr;
                    m_data = m_pick_b ? b_if.wdata : a_if.wdata;
                    gq[m_pick_b][tl[m_pick_b] % QN] = cyc;
                    dq[m_pick_b][tl[m_pick_b] % QN] = '{cyc: cyc + 1, is_rd: !m_we, data: ref_mem[m_addr]};
                    tl[m_pick_b] = tl[m_pick_b] + 1;
                    if (m_we) begin
                        ref_mem[m_addr] = m_data;
                        wr_cyc   = cyc;
                        wr_addr  = m_addr;
                        wr_data  = m_data;
                        busy_cnt = 2;
                    end else begin
                        rd_cyc   = cyc;
                        rd_addr  = m_addr;
                        busy_cnt = 1;
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard -----------------------------------
    int            n_checks = 0;
    int            n_fail   = 0;
    int            gh [2]   = '{0, 0};
    int            dh [2]   = '{0, 0};
    logic [DW-1:0] held [2] = '{default: '0};
    bit            tmo [2]  = '{0, 0};
    bit            end_req  = 1'b0;
    logic          mo_g, mo_d, exp_g, exp_d;
    logic [DW-1:0] mo_rd;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (!ok) begin
            n_fail = n_fail + 1;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (!rst_n) begin
                check({a_if.gnt, a_if.done, b_if.gnt, b_if.done, busy, ram_we, ram_en} == 7'b0,
                      "reset_ctrl", {a_if.gnt, a_if.done, b_if.gnt, b_if.done, busy, ram_we, ram_en}, 0);
                check(ram_addr == '0, "reset_addr", ram_addr, 0);
                check(a_if.rdata == '0 && b_if.rdata == '0, "reset_rdata", {a_if.rdata, b_if.rdata}, 0);
                for (int w = 0; w < 2; w++) begin
                    gh[w]   = tl[w];
                    dh[w]   = tl[w];
                    held[w] = '0;
                end
            end else begin
                check(!(ram_we && ram_en), "we_en_exclusive", {ram_we, ram_en}, 0);
                check(busy == (busy_cnt != 0), "busy", busy, busy_cnt != 0);
                check(ram_we == (wr_cyc == cyc), "ram_we", ram_we, wr_cyc == cyc);
                if (wr_cyc == cyc) begin
                    check(ram_addr == wr_addr, "wr_addr", ram_addr, wr_addr);
                    check(ram_data == wr_data, "wr_bus_data", ram_data, wr_data);
                end
                check(ram_en == (rd_cyc == cyc), "ram_en", ram_en, rd_cyc == cyc);
                if (rd_cyc == cyc) check(ram_addr == rd_addr, "rd_addr", ram_addr, rd_addr);
                for (int w = 0; w < 2; w++) begin
                    mo_g  = w ? b_if.gnt   : a_if.gnt;
                    mo_d  = w ? b_if.done  : a_if.done;
                    mo_rd = w ? b_if.rdata : a_if.rdata;
                    while (gh[w] != tl[w] && gq[w][gh[w] % QN] < cyc) begin
                        check(1'b0, w ? "gnt_b_missing" : "gnt_a_missing", 0, gq[w][gh[w] % QN]);
                        gh[w] = gh[w] + 1;
                    end
                    exp_g = (gh[w] != tl[w]) && (gq[w][gh[w] % QN] == cyc);
                    check(mo_g == exp_g, w ? "gnt_b" : "gnt_a", mo_g, exp_g);
                    if (exp_g) gh[w] = gh[w] + 1;
                    while (dh[w] != tl[w] && dq[w][dh[w] % QN].cyc < cyc) begin
                        check(1'b0, w ? "done_b_missing" : "done_a_missing", 0, dq[w][dh[w] % QN].cyc);
                        dh[w] = dh[w] + 1;
                    end
                    exp_d = (dh[w] != tl[w]) && (dq[w][dh[w] % QN].cyc == cyc);
                    check(mo_d == exp_d, w ? "done_b" : "done_a", mo_d, exp_d);
                    if (exp_d) begin
                        if (dq[w][dh[w] % QN].is_rd) held[w] = dq[w][dh[w] % QN].data;
                        dh[w] = dh[w] + 1;
                    end
                    check(mo_rd == held[w], w ? "rdata_b" : "rdata_a", mo_rd, held[w]);
                end
            end
            if (end_req || cyc > 30000) begin
                check(cyc <= 30000, "watchdog", cyc, 30000);
                check(gh[0] == tl[0] && gh[1] == tl[1], "all_granted", {gh[0], gh[1]}, {tl[0], tl[1]});
                check(dh[0] == tl[0] && dh[1] == tl[1], "all_done", {dh[0], dh[1]}, {tl[0], tl[1]});
                check(!tmo[0] && !tmo[1], "gnt_timeout", {tmo[0], tmo[1]}, 0);
                $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
                $finish;
            end
        end
    end

    // ---------------- stimulus -----------------------------------------------
    task automatic drop(input int w);
        if (w == 0) a_if.req = 1'b0;
        else        b_if.req = 1'b0;
    endtask

    // Present a command and hold it until granted; returns just after the grant edge.
    task automatic issue(input int w, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        int n;
        logic g;
        if (w == 0) begin a_if.req = 1'b1; a_if.we = we; a_if.addr = addr; a_if.wdata = d; end
        else        begin b_if.req = 1'b1; b_if.we = we; b_if.addr = addr; b_if.wdata = d; end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n = n + 1;
            g = (w == 0) ? a_if.gnt : b_if.gnt;
        end while (!g && n < 20);
        if (!g) tmo[w] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rnd_traffic(input int w);
        int gap;
        for (int i = 0; i < 30; i++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                drop(w);
                idle(gap);
            end
            issue(w, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
        end
        drop(w);
    endtask

    initial begin
        a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.wdata = '0;
        b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.wdata = '0;
        idle(3);
        rst_n = 1'b1;
        idle(10);

        issue(0, 1'b1, 3'd3, 16'hBEEF); drop(0);
        issue(0, 1'b0, 3'd3, 16'h0);    drop(0);
        idle(3);

        issue(0, 1'b1, 3'd0, 16'h1111); drop(0);
        issue(1, 1'b1, 3'd7, 16'h7777); drop(1);
        idle(3);
        fork
            begin repeat (4) issue(0, 1'b0, 3'd0, 16'h0); drop(0); end
            begin repeat (4) issue(1, 1'b0, 3'd7, 16'h0); drop(1); end
        join
        idle(3);

        issue(1, 1'b1, 3'd5, 16'hA5A5); drop(1);
        issue(0, 1'b0, 3'd5, 16'h0);    drop(0);
        idle(3);

        for (int i = 0; i < DEPTH; i++) issue(0, 1'b1, 3'(i), 16'(16'h0100 * i));
        for (int i = 0; i < DEPTH; i++) issue(0, 1'b0, 3'(i), 16'h0);
        drop(0);
        idle(3);

        fork
            rnd_traffic(0);
            rnd_traffic(1);
        join
        idle(4);

        // Abort a write while it is on the bus, then confirm normal service resumes.
        issue(0, 1'b1, 3'd6, 16'hDEAD);
        #2;
        rst_n = 1'b0;
        drop(0);
        idle(3);
        rst_n = 1'b1;
        idle(2);
        issue(0, 1'b0, 3'd2, 16'h0); drop(0);
        idle(6);
        end_req = 1'b1;
    end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Clocked two-requester arbiter and sequencer for the 8x16 asynchronous single-port RAM with the shared bidirectional data bus.
- Owns the RAM's addr/we/en pins and the tri-state data bus. Serialises read/write commands from requester A and requester B with round-robin fairness.
- Guarantees one bus-turnaround cycle after every write, so the controller and the RAM never drive the bus together.
- Sits between two clocked masters (for example, a DMA engine and a CPU-side port) and the asynchronous RAM macro.

Parameters:
- DATA_WIDTH, 16, RAM word width.
- DATA_ADDR, 3, RAM address width (depth = 2**DATA_ADDR).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_a  in  1  requester A command request; level, held until gnt_a.
- we_a  in  1  A: 1 = write, 0 = read.
- addr_a  in  DATA_ADDR  A word address.
- wdata_a  in  DATA_WIDTH  A write data.
- gnt_a  out  1  one-cycle pulse: A's command was accepted.
- done_a  out  1  one-cycle pulse: A's access is complete.
- rdata_a  out  DATA_WIDTH  A read data; valid from done_a and held until A's next read completes.
- req_b, we_b, addr_b, wdata_b, gnt_b, done_b, rdata_b  same as the A ports, for requester B.
- busy  out  1  high whenever the FSM is not in IDLE.
- ram_addr  out  DATA_ADDR  to RAM addr_in.
- ram_we  out  1  to RAM we_in.
- ram_en  out  1  to RAM en_in.
- ram_data  inout  DATA_WIDTH  to RAM data bus.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - gnt_*, done_*, busy, ram_we, ram_en = 0.
  - ram_addr = 0; rdata_* = 0.
  - ram_data driven Z.
  - RR pointer set to last_served=B, so A wins first.
- RAM pin encoding (fixed by the macro):
  - Write = we=1, en=0.
  - Read = en=1, we=0.
  - Idle = we=0, en=0.
  - we=1 with en=1 is never produced.
- Bus drive: ram_data is driven only in WR and WR_HOLD; it is Z in all other states and during reset.
- All outputs are registered; no combinational path from req_* to any output.
- FSM states: IDLE, WR, WR_HOLD, RD.
- IDLE:
  - If no req is pending, stay in IDLE.
  - If only one req is high, select that requester.
  - If both are high, select the one not equal to last_served.
  - On the edge: latch we/addr/wdata of the selected requester, update last_served, pulse gnt_x in the next cycle, and go to WR (we=1) or RD (we=0).
- WR (1 cycle): ram_addr=latched address, ram_we=1, ram_en=0, ram_data=latched wdata. Next state WR_HOLD.
- WR_HOLD (1 cycle):
  - ram_we=0, ram_en=0; addr and data held for RAM hold time.
  - done_x pulses this cycle.
  - Next state IDLE.
- RD (1 cycle):
  - ram_en=1, ram_we=0, ram_data=Z.
  - At the end-of-cycle edge, capture ram_data into rdata_x and pulse done_x in the following cycle.
  - Next state IDLE.
- Latency (req sampled at edge k):
  - gnt in cycle k+1.
  - Write done in cycle k+2.
  - Read done and rdata valid in cycle k+2.
- Throughput:
  - Write: 3 cycles per access (IDLE, WR, WR_HOLD).
  - Read: 2 cycles per access (IDLE, RD).
- Requester rule: req_x must be low on the edge after gnt_x unless a new command is intended. A req still high in IDLE is treated as a new command.
- Non-selected requester: its pending req simply waits, with no limit on how long it is held. Round-robin bounds its wait to one access by the other requester.
- rdata_x updates only on completion of x's own read; the other requester's reads and any writes leave it unchanged.
- Address wrap: none; every address 0..2**DATA_ADDR-1 is valid.
- Reset mid-operation: aborts immediately.
  - The bus is released and we/en go low.
  - An in-flight write may or may not have updated the RAM.
  - No done pulse is issued for the aborted access.

Test Plan:
- Reset release, no requests -> all outputs 0, ram_data Z, busy=0 for 10 cycles.
- A writes 16'hBEEF to addr 3, then A reads addr 3 -> gnt_a at k+1; ram_we=1 for exactly 1 cycle; done_a at k+2; the read returns rdata_a=16'hBEEF at done_a.
- A and B request in the same cycle, both reads of addr 0 and addr 7 (preloaded 16'h1111 and 16'h7777), req held continuously -> A served first, then B, then A, alternating. rdata_a=16'h1111, rdata_b=16'h7777; rdata_a unchanged by B's read.
- B write immediately followed by A read of the same address 5 (data 16'hA5A5) -> WR_HOLD cycle present, no cycle with ram_data driven while ram_en=1; rdata_a=16'hA5A5.
- Back-to-back writes to addresses 0..7 (data 16'h0100*i) then reads 0..7 -> all 8 match; each write takes 3 cycles, each read 2.
- rst_n asserted during WR -> on the same delta ram_we=0, ram_data Z, no done; after release, the next A read succeeds normally.
